// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM state encoding and serial line levels for the frame receiver
package serial_pkg;
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK} state_t;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
endpackage

// File: rtl/serial_shift_in.sv
// serial_shift_in: LSB-first shift register, bit counter and even-parity accumulator
// ports: clk, rst_n (async low), clear (restart count/parity), shift (take bit_in),
//        data (assembled word), last (current shift is the final data bit), parity (XOR of bits so far)
module serial_shift_in #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  shift,
  input  logic                  bit_in,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last,
  output logic                  parity
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] next_data;
  generate
    if (DATA_WIDTH == 1) begin : g_one
      assign next_data = bit_in;
    end else begin : g_many
      // bits enter at the MSB so the first received bit ends up at bit 0
      assign next_data = {bit_in, data[DATA_WIDTH-1:1]};
    end
  endgenerate
  assign last = cnt == CW'(DATA_WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data   <= '0;
      cnt    <= '0;
      parity <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      parity <= 1'b0;
    end else if (shift) begin
      data   <= next_data;
      cnt    <= cnt + CW'(1);
      parity <= parity ^ bit_in;
    end
  end
endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: framed serial receiver with parity/stop checking and a one-entry output register
// ports: clk, rst_n (async low), serialIn (idle high), outData/outValid/outReady (valid-ready output),
//        parityErr, frameErr, overrun (one-cycle error pulses)
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  serialIn,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  parityErr,
  output logic                  frameErr,
  output logic                  overrun
);
  state_t                state, next_state;
  logic                  clear, shift, last, par_acc, par_bad;
  logic [DATA_WIDTH-1:0] sr_data;
  logic                  stop_now, stop_ok, good, drain, load;
  serial_shift_in #(.DATA_WIDTH(DATA_WIDTH)) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .shift  (shift),
    .bit_in (serialIn),
    .data   (sr_data),
    .last   (last),
    .parity (par_acc)
  );
  always_comb begin
    next_state = state;
    clear      = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        clear      = serialIn == START_LEVEL;
        next_state = serialIn == START_LEVEL ? DATA : IDLE;
      end
      DATA: begin
        shift      = 1'b1;
        next_state = !last ? DATA : PARITY_EN ? PARITY : STOP;
      end
      PARITY: next_state = STOP;
      STOP:   next_state = serialIn == STOP_LEVEL ? IDLE : BREAK;
      BREAK:  next_state = serialIn == IDLE_LEVEL ? IDLE : BREAK;
      default: next_state = IDLE;
    endcase
  end
  // a bad stop bit masks any parity result; a good frame may refill a slot drained this same edge
  assign stop_now = state == STOP;
  assign stop_ok  = serialIn == STOP_LEVEL;
  assign good     = stop_now && stop_ok && !par_bad;
  assign drain    = outValid && outReady;
  assign load     = good && (!outValid || drain);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      par_bad   <= 1'b0;
      outData   <= '0;
      outValid  <= 1'b0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= next_state;
      par_bad   <= clear ? 1'b0 : state == PARITY ? par_acc ^ serialIn : par_bad;
      parityErr <= stop_now && stop_ok && par_bad;
      frameErr  <= stop_now && !stop_ok;
      overrun   <= good && outValid && !outReady;
      outData   <= load ? sr_data : outData;
      outValid  <= load ? 1'b1 : drain ? 1'b0 : outValid;
    end
  end
endmodule
